// File: rtl/latency_stamp_pkg.sv
// Shared types and helpers for the multi-channel latency stamp array.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package latency_stamp_pkg;

    localparam int TS_W_DEFAULT = 64;
    localparam int CH_W_MAX     = 4;    // enough for up to 16 channels

    // Channel index width; a single channel still gets a 1-bit field.
    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Result record in the default configuration, for downstream consumers.
    typedef struct packed {
        logic [CH_W_MAX-1:0]     ch;
        logic [TS_W_DEFAULT-1:0] ts_tx;
        logic [TS_W_DEFAULT-1:0] delta;
    } stamp_res_t;

endpackage

// File: rtl/stamp_fifo.sv
// Synchronous first-word-fall-through FIFO holding TX timestamps.
// Latency: push visible at dout/empty one cycle later; head always on dout.
// Backpressure: push ignored when full unless a pop happens the same cycle.
//
// Ports: clk, rst (sync, active-high), push/din, pop, dout (head), full, empty.
module stamp_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // When full, a same-cycle pop frees the head slot, which is exactly
    // the slot wr_ptr points at, so the push can land there.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/latency_stamp_array.sv
// Per-channel TX stamp queues matched in order by RX events; latency results
// merged round-robin onto one valid/ready stream.
// Latency: rx_pulse at N -> slot at N+1 -> res_valid at N+2 (uncontended).
// Backpressure: res_valid/res_* held until res_ready; a full, undrained
// channel slot discards the new result and flags err_res_drop.
//
// Ports: clk, rst, clear (flush), ts_in, tx_pulse/rx_pulse per channel,
// res_valid/res_ready/res_ch/res_ts_tx/res_delta result stream,
// sticky err_tx_ovf / err_rx_orphan / err_res_drop per channel.
module latency_stamp_array
    import latency_stamp_pkg::*;
#(
    parameter int TS_W   = TS_W_DEFAULT,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [TS_W-1:0]           ts_in,
    input  logic [NUM_CH-1:0]         tx_pulse,
    input  logic [NUM_CH-1:0]         rx_pulse,
    input  logic                      clear,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [ch_w(NUM_CH)-1:0]   res_ch,
    output logic [TS_W-1:0]           res_ts_tx,
    output logic [TS_W-1:0]           res_delta,
    output logic [NUM_CH-1:0]         err_tx_ovf,
    output logic [NUM_CH-1:0]         err_rx_orphan,
    output logic [NUM_CH-1:0]         err_res_drop
);

    localparam int CW = ch_w(NUM_CH);

    typedef struct packed {
        logic [CW-1:0]   ch;
        logic [TS_W-1:0] ts_tx;
        logic [TS_W-1:0] delta;
    } res_t;

    logic              flush;
    logic [NUM_CH-1:0] q_push;
    logic [NUM_CH-1:0] q_pop;
    logic [NUM_CH-1:0] q_full;
    logic [NUM_CH-1:0] q_empty;
    logic [TS_W-1:0]   q_head     [NUM_CH];
    logic [NUM_CH-1:0] slot_vld;
    logic [TS_W-1:0]   slot_ts    [NUM_CH];
    logic [TS_W-1:0]   slot_delta [NUM_CH];
    logic [NUM_CH-1:0] grant;

    logic              load;
    logic              found;
    logic [CW-1:0]     sel;
    logic [CW-1:0]     rr_ptr;
    res_t              out_q;
    logic              out_vld;

    assign flush = rst | clear;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic            hit;
        logic            vld_r;
        logic [TS_W-1:0] ts_r;
        logic [TS_W-1:0] delta_r;
        logic            ovf_r;
        logic            orphan_r;
        logic            drop_r;

        // clear wins over any pulse arriving in the same cycle.
        assign q_push[c] = tx_pulse[c] & ~clear;
        assign q_pop[c]  = rx_pulse[c] & ~clear;
        assign hit       = q_pop[c] & ~q_empty[c];

        stamp_fifo #(
            .W     (TS_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (flush),
            .push  (q_push[c]),
            .pop   (q_pop[c]),
            .din   (ts_in),
            .dout  (q_head[c]),
            .full  (q_full[c]),
            .empty (q_empty[c])
        );

        always_ff @(posedge clk) begin
            if (flush) begin
                vld_r    <= 1'b0;
                ts_r     <= '0;
                delta_r  <= '0;
                ovf_r    <= 1'b0;
                orphan_r <= 1'b0;
                drop_r   <= 1'b0;
            end else begin
                // Slot is free to take a new result if empty or being
                // granted to the output register in this same cycle.
                if (hit && (!vld_r || grant[c])) begin
                    vld_r   <= 1'b1;
                    ts_r    <= q_head[c];
                    delta_r <= ts_in - q_head[c];
                end else if (grant[c]) begin
                    vld_r <= 1'b0;
                end
                if (hit && vld_r && !grant[c])              drop_r   <= 1'b1;
                // A full queue with a same-cycle RX pops and pushes: no loss.
                if (q_push[c] && q_full[c] && !q_pop[c])    ovf_r    <= 1'b1;
                if (q_pop[c] && q_empty[c])                 orphan_r <= 1'b1;
            end
        end

        assign slot_vld[c]      = vld_r;
        assign slot_ts[c]       = ts_r;
        assign slot_delta[c]    = delta_r;
        assign err_tx_ovf[c]    = ovf_r;
        assign err_rx_orphan[c] = orphan_r;
        assign err_res_drop[c]  = drop_r;
    end

    // Output register may take a new result when empty or being accepted.
    assign load = ~out_vld | res_ready;

    // Round-robin pick: first valid slot at or after rr_ptr.
    always_comb begin
        int idx;
        grant = '0;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        if (load) begin
            for (int i = 0; i < NUM_CH; i++) begin
                idx = (int'(rr_ptr) + i) % NUM_CH;
                if (!found && slot_vld[idx]) begin
                    found = 1'b1;
                    sel   = CW'(idx);
                end
            end
        end
        if (found) grant[sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            out_vld <= 1'b0;
            out_q   <= '0;
            rr_ptr  <= '0;
        end else if (load) begin
            if (found) begin
                out_vld     <= 1'b1;
                out_q.ch    <= sel;
                out_q.ts_tx <= slot_ts[sel];
                out_q.delta <= slot_delta[sel];
                rr_ptr      <= (sel == CW'(NUM_CH - 1)) ? '0 : sel + 1'b1;
            end else begin
                out_vld <= 1'b0;
            end
        end
    end

    assign res_valid = out_vld;
    assign res_ch    = out_q.ch;
    assign res_ts_tx = out_q.ts_tx;
    assign res_delta = out_q.delta;

endmodule

// File: tb/tb_latency_stamp_array.sv
module tb_latency_stamp_array;

    localparam int TS_W   = 64;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 8;

    logic              clk;
    logic              rst;
    logic [TS_W-1:0]   ts_in;
    logic [NUM_CH-1:0] tx_pulse;
    logic [NUM_CH-1:0] rx_pulse;
    logic              clear;
    logic              res_valid;
    logic              res_ready;
    logic [1:0]        res_ch;
    logic [TS_W-1:0]   res_ts_tx;
    logic [TS_W-1:0]   res_delta;
    logic [NUM_CH-1:0] err_tx_ovf;
    logic [NUM_CH-1:0] err_rx_orphan;
    logic [NUM_CH-1:0] err_res_drop;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [1:0]      ch;
        logic [TS_W-1:0] ts;
        logic [TS_W-1:0] d;
    } rec_t;

    rec_t q[$];

    latency_stamp_array #(
        .TS_W   (TS_W),
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ts_in         (ts_in),
        .tx_pulse      (tx_pulse),
        .rx_pulse      (rx_pulse),
        .clear         (clear),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_ch        (res_ch),
        .res_ts_tx     (res_ts_tx),
        .res_delta     (res_delta),
        .err_tx_ovf    (err_tx_ovf),
        .err_rx_orphan (err_rx_orphan),
        .err_res_drop  (err_res_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every handshake; the transfer completes at the following edge.
    always @(negedge clk) begin
        if (!rst && !clear && res_valid === 1'b1 && res_ready === 1'b1)
            q.push_back({res_ch, res_ts_tx, res_delta});
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; clear = 1'b0; tx_pulse = '0; rx_pulse = '0;
        ts_in = '0; res_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        q.delete();
    endtask

    task automatic wait_q(input int n);
        for (int i = 0; i < 60 && q.size() < n; i++) step();
        repeat (4) step();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", res_valid); end
        n_cmp++; if (res_ch !== 2'd0) begin n_bad++; $display("FAIL reset_ch: got %0d want 0", res_ch); end
        n_cmp++; if (res_ts_tx !== 64'd0) begin n_bad++; $display("FAIL reset_ts: got %0d want 0", res_ts_tx); end
        n_cmp++; if (res_delta !== 64'd0) begin n_bad++; $display("FAIL reset_delta: got %0d want 0", res_delta); end
        n_cmp++; if ({err_tx_ovf, err_rx_orphan, err_res_drop} !== 12'd0) begin
            n_bad++; $display("FAIL reset_err: got %h want 0", {err_tx_ovf, err_rx_orphan, err_res_drop});
        end
    endtask

    task automatic test_single_pair();
        do_reset();
        tx_pulse = 4'b0001; ts_in = 64'd100; step();
        tx_pulse = 4'b0000;
        rx_pulse = 4'b0001; ts_in = 64'd350; step();
        rx_pulse = 4'b0000;
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL pair_valid_n1: got %0b want 0", res_valid); end
        step();
        n_cmp++; if (res_valid !== 1'b1) begin n_bad++; $display("FAIL pair_valid_n2: got %0b want 1", res_valid); end
        n_cmp++; if (res_ch !== 2'd0) begin n_bad++; $display("FAIL pair_ch: got %0d want 0", res_ch); end
        n_cmp++; if (res_ts_tx !== 64'd100) begin n_bad++; $display("FAIL pair_ts: got %0d want 100", res_ts_tx); end
        n_cmp++; if (res_delta !== 64'd250) begin n_bad++; $display("FAIL pair_delta: got %0d want 250", res_delta); end
        wait_q(1);
        n_cmp++; if (q.size() != 1) begin n_bad++; $display("FAIL pair_count: got %0d want 1", q.size()); end
    endtask

    task automatic test_ordering();
        logic [63:0] tx_ts [3] = '{64'd10, 64'd20, 64'd30};
        logic [63:0] rx_ts [3] = '{64'd50, 64'd55, 64'd70};
        logic [63:0] exp_d [3] = '{64'd40, 64'd35, 64'd40};
        do_reset();
        for (int i = 0; i < 3; i++) begin tx_pulse = 4'b0010; ts_in = tx_ts[i]; step(); end
        tx_pulse = '0;
        for (int i = 0; i < 3; i++) begin rx_pulse = 4'b0010; ts_in = rx_ts[i]; step(); end
        rx_pulse = '0;
        wait_q(3);
        n_cmp++; if (q.size() != 3) begin n_bad++; $display("FAIL order_count: got %0d want 3", q.size()); end
        for (int i = 0; i < 3 && i < q.size(); i++) begin
            n_cmp++;
            if (q[i].ch !== 2'd1 || q[i].ts !== tx_ts[i] || q[i].d !== exp_d[i]) begin
                n_bad++;
                $display("FAIL order_res%0d: got ch=%0d ts=%0d d=%0d want ch=1 ts=%0d d=%0d",
                         i, q[i].ch, q[i].ts, q[i].d, tx_ts[i], exp_d[i]);
            end
        end
        n_cmp++; if (err_res_drop !== 4'b0000) begin n_bad++; $display("FAIL order_nodrop: got %b want 0000", err_res_drop); end
    endtask

    task automatic test_overflow_orphan();
        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin tx_pulse = 4'b0100; ts_in = 64'(1000 + i); step(); end
        tx_pulse = '0;
        n_cmp++; if (err_tx_ovf !== 4'b0100) begin n_bad++; $display("FAIL ovf_flag: got %b want 0100", err_tx_ovf); end
        for (int i = 0; i < DEPTH; i++) begin rx_pulse = 4'b0100; ts_in = 64'(2000 + i); step(); end
        rx_pulse = '0;
        wait_q(DEPTH);
        n_cmp++; if (q.size() != DEPTH) begin n_bad++; $display("FAIL ovf_count: got %0d want %0d", q.size(), DEPTH); end
        for (int i = 0; i < DEPTH && i < q.size(); i++) begin
            n_cmp++;
            if (q[i].ch !== 2'd2 || q[i].ts !== 64'(1000 + i) || q[i].d !== 64'd1000) begin
                n_bad++;
                $display("FAIL ovf_res%0d: got ch=%0d ts=%0d d=%0d want ch=2 ts=%0d d=1000",
                         i, q[i].ch, q[i].ts, q[i].d, 1000 + i);
            end
        end
        n_cmp++; if (err_rx_orphan !== 4'b0000) begin n_bad++; $display("FAIL ovf_no_orphan: got %b want 0000", err_rx_orphan); end
        rx_pulse = 4'b1000; ts_in = 64'd3000; step();
        rx_pulse = '0;
        n_cmp++; if (err_rx_orphan !== 4'b1000) begin n_bad++; $display("FAIL orphan_flag: got %b want 1000", err_rx_orphan); end
        repeat (5) step();
        n_cmp++; if (q.size() != DEPTH) begin n_bad++; $display("FAIL orphan_nores: got %0d want %0d", q.size(), DEPTH); end
    endtask

    task automatic test_wrap();
        do_reset();
        tx_pulse = 4'b0001; ts_in = 64'hFFFF_FFFF_FFFF_FFFB; step();
        tx_pulse = '0;
        rx_pulse = 4'b0001; ts_in = 64'd3; step();
        rx_pulse = '0;
        wait_q(1);
        n_cmp++;
        if (q.size() != 1 || q[0].ts !== 64'hFFFF_FFFF_FFFF_FFFB || q[0].d !== 64'd8) begin
            n_bad++;
            $display("FAIL wrap_delta: got n=%0d ts=%h d=%0d want n=1 ts=fffffffffffffffb d=8",
                     q.size(), (q.size() > 0) ? q[0].ts : 64'd0, (q.size() > 0) ? q[0].d : 64'd0);
        end
    endtask

    task automatic test_contention();
        do_reset();
        res_ready = 1'b0;
        tx_pulse = 4'b1111; ts_in = 64'd100; step();
        tx_pulse = 4'b0010; ts_in = 64'd200; step();
        tx_pulse = '0;
        rx_pulse = 4'b1111; ts_in = 64'd300; step();
        rx_pulse = '0;
        step();
        repeat (4) step();
        n_cmp++; if (res_valid !== 1'b1 || res_ch !== 2'd0) begin
            n_bad++; $display("FAIL stall_hold: got v=%0b ch=%0d want v=1 ch=0", res_valid, res_ch);
        end
        n_cmp++; if (err_res_drop !== 4'b0000) begin n_bad++; $display("FAIL stall_nodrop: got %b want 0000", err_res_drop); end
        rx_pulse = 4'b0010; ts_in = 64'd400; step();
        rx_pulse = '0;
        n_cmp++; if (err_res_drop !== 4'b0010) begin n_bad++; $display("FAIL drop_flag: got %b want 0010", err_res_drop); end
        res_ready = 1'b1;
        wait_q(4);
        n_cmp++; if (q.size() != 4) begin n_bad++; $display("FAIL cont_count: got %0d want 4", q.size()); end
        for (int i = 0; i < 4 && i < q.size(); i++) begin
            n_cmp++;
            if (q[i].ch !== 2'(i) || q[i].ts !== 64'd100 || q[i].d !== 64'd200) begin
                n_bad++;
                $display("FAIL cont_res%0d: got ch=%0d ts=%0d d=%0d want ch=%0d ts=100 d=200",
                         i, q[i].ch, q[i].ts, q[i].d, i);
            end
        end
    endtask

    task automatic test_clear();
        do_reset();
        rx_pulse = 4'b1000; ts_in = 64'd5; step();
        rx_pulse = '0;
        for (int i = 0; i < 3; i++) begin tx_pulse = 4'b0001; ts_in = 64'(10 + i); step(); end
        tx_pulse = '0;
        n_cmp++; if (err_rx_orphan !== 4'b1000) begin n_bad++; $display("FAIL clr_pre: got %b want 1000", err_rx_orphan); end
        clear = 1'b1; tx_pulse = 4'b0001; ts_in = 64'd20; step();
        clear = 1'b0; tx_pulse = '0;
        n_cmp++; if ({err_tx_ovf, err_rx_orphan, err_res_drop} !== 12'd0) begin
            n_bad++; $display("FAIL clr_err: got %h want 0", {err_tx_ovf, err_rx_orphan, err_res_drop});
        end
        rx_pulse = 4'b0001; ts_in = 64'd500; step();
        rx_pulse = '0;
        n_cmp++; if (err_rx_orphan !== 4'b0001) begin n_bad++; $display("FAIL clr_orphan: got %b want 0001", err_rx_orphan); end
        repeat (6) step();
        n_cmp++; if (q.size() != 0 || res_valid !== 1'b0) begin
            n_bad++; $display("FAIL clr_nores: got n=%0d v=%0b want n=0 v=0", q.size(), res_valid);
        end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; tx_pulse = '0; rx_pulse = '0;
        ts_in = '0; res_ready = 1'b1;
        test_reset();
        test_single_pair();
        test_ordering();
        test_overflow_orphan();
        test_wrap();
        test_contention();
        test_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
